// File: rtl/pma_link_ctrl_pkg.sv
// Shared constants and encodings for the PMA link controller.
// Imported by the interface-facing top and by the RX word matcher.
package pma_link_ctrl_pkg;

  localparam logic [9:0] K285_RDN = 10'b0011111010;
  localparam logic [9:0] K285_RDP = 10'b1100000101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_LINKED = 2'd2,
    ST_FAIL   = 2'd3
  } link_state_t;

  typedef enum logic [1:0] {
    MC_NONE = 2'd0,
    MC_GOOD = 2'd1,
    MC_INV  = 2'd2
  } match_cls_t;

  function automatic logic is_comma(input logic [9:0] w);
    return (w == K285_RDN) || (w == K285_RDP);
  endfunction

endpackage

// File: rtl/pma_link_ctrl_if.sv
// MAC/PMA-facing signal bundle of the link controller.
// master = controller side, slave = MAC + PMA environment.
interface pma_link_ctrl_if #(parameter int DATA_WIDTH = 10);
  logic                  link_req;
  logic [DATA_WIDTH-1:0] mac_data;
  logic                  mac_valid;
  logic                  mac_ready;
  logic [DATA_WIDTH-1:0] rx_word;
  logic [DATA_WIDTH-1:0] pma_data;
  logic                  pma_data_en;
  logic                  RxPolarity;
  logic                  link_up;
  logic                  link_fail;
  logic [1:0]            state;

  modport master (
    input  link_req, mac_data, mac_valid, rx_word,
    output mac_ready, pma_data, pma_data_en, RxPolarity, link_up, link_fail, state
  );

  modport slave (
    output link_req, mac_data, mac_valid, rx_word,
    input  mac_ready, pma_data, pma_data_en, RxPolarity, link_up, link_fail, state
  );
endinterface

// File: rtl/pma_link_ctrl_word_matcher.sv
// RX word matcher: registers the aligned RX word, classifies it and keeps
// saturating run-length counters of good / inverted-polarity words.
module pma_word_matcher
  import pma_link_ctrl_pkg::*;
#(
  parameter int         DATA_WIDTH = 10,
  parameter logic [9:0] TRAIN_WORD = 10'b0110110101,
  parameter int         LOCK_CNT   = 16
) (
  input  logic                  Bit_Rate_Clk_10,
  input  logic                  Rst_n,
  input  logic [DATA_WIDTH-1:0] rx_word,
  input  logic                  cnt_en,
  output logic                  lock,
  output logic                  inv_lock,
  output logic                  comma_seen
);

  localparam int            CW       = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_CNT);

  logic [DATA_WIDTH-1:0] rx_q;
  logic [CW-1:0]         good_cnt;
  logic [CW-1:0]         inv_cnt;
  match_cls_t            cls;

  always_ff @(posedge Bit_Rate_Clk_10 or negedge Rst_n) begin
    if (!Rst_n) rx_q <= '0;
    else        rx_q <= rx_word;
  end

  // Either comma disparity counts as good: the TX alternates K28.5 and TRAIN_WORD.
  always_comb begin
    cls = MC_NONE;
    if (is_comma(rx_q) || rx_q == TRAIN_WORD) cls = MC_GOOD;
    else if (rx_q == ~TRAIN_WORD)             cls = MC_INV;
  end

  always_ff @(posedge Bit_Rate_Clk_10 or negedge Rst_n) begin
    if (!Rst_n) begin
      good_cnt <= '0;
      inv_cnt  <= '0;
    end else if (!cnt_en) begin
      good_cnt <= '0;
      inv_cnt  <= '0;
    end else begin
      unique case (cls)
        MC_GOOD: begin
          good_cnt <= (good_cnt == LOCK_MAX) ? good_cnt : good_cnt + 1'b1;
          inv_cnt  <= '0;
        end
        MC_INV: begin
          inv_cnt  <= (inv_cnt == LOCK_MAX) ? inv_cnt : inv_cnt + 1'b1;
          good_cnt <= '0;
        end
        default: begin
          good_cnt <= '0;
          inv_cnt  <= '0;
        end
      endcase
    end
  end

  assign lock       = (good_cnt == LOCK_MAX);
  assign inv_lock   = (inv_cnt == LOCK_MAX);
  assign comma_seen = is_comma(rx_word);

endmodule

// File: rtl/pma_link_ctrl.sv
// PMA link bring-up controller: training, polarity correction, retry/fail,
// then MAC pass-through with periodic K28.5 skips and comma-loss supervision.
//
//  state  | meaning
//  IDLE   | link not requested, PMA TX disabled
//  TRAIN  | sending K28.5/TRAIN_WORD, waiting for RX lock
//  LINKED | MAC data forwarded, skip insertion, comma-loss watch
//  FAIL   | retries exhausted, TX off, held until link_req drops
module pma_link_ctrl
  import pma_link_ctrl_pkg::*;
#(
  parameter int         DATA_WIDTH  = 10,
  parameter logic [9:0] TRAIN_WORD  = 10'b0110110101,
  parameter int         LOCK_CNT    = 16,
  parameter int         TIMEOUT_CYC = 4096,
  parameter int         MAX_RETRY   = 3,
  parameter int         SKIP_INT    = 256,
  parameter int         LOSS_CYC    = 1024
) (
  input  logic           Bit_Rate_Clk_10,
  input  logic           Rst_n,
  pma_link_ctrl_if.master bus
);

  localparam int             TMW       = $clog2(TIMEOUT_CYC + 1);
  localparam int             RW        = $clog2(MAX_RETRY + 1);
  localparam int             SW        = $clog2(SKIP_INT + 1);
  localparam int             LW        = $clog2(LOSS_CYC + 1);
  localparam logic [TMW-1:0] TMO_LAST  = TMW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0]  RTY_LAST  = RW'(MAX_RETRY - 1);
  localparam logic [SW-1:0]  SKIP_LAST = SW'(SKIP_INT - 1);
  localparam logic [LW-1:0]  LOSS_LAST = LW'(LOSS_CYC - 1);

  link_state_t           st, ns;
  logic [TMW-1:0]        tmr;
  logic [RW-1:0]         retry_cnt;
  logic [SW-1:0]         skip_cnt;
  logic [LW-1:0]         loss_cnt;
  logic                  rx_pol, flip_done, train_ph;
  logic [DATA_WIDTH-1:0] pma_data_q;
  logic                  pma_en_q;

  logic lock, inv_lock, comma_seen;
  logic flip, retry, give_up, cnt_en, linked_run, mac_ready_c;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic                  nxt_en, nxt_ph;

  pma_word_matcher #(
    .DATA_WIDTH (DATA_WIDTH),
    .TRAIN_WORD (TRAIN_WORD),
    .LOCK_CNT   (LOCK_CNT)
  ) u_matcher (
    .Bit_Rate_Clk_10 (Bit_Rate_Clk_10),
    .Rst_n           (Rst_n),
    .rx_word         (bus.rx_word),
    .cnt_en          (cnt_en),
    .lock            (lock),
    .inv_lock        (inv_lock),
    .comma_seen      (comma_seen)
  );

  always_ff @(posedge Bit_Rate_Clk_10 or negedge Rst_n) begin
    if (!Rst_n) st <= ST_IDLE;
    else        st <= ns;
  end

  // A second inverted lock after a flip means the line is unusable: retry.
  always_comb begin
    ns      = st;
    flip    = 1'b0;
    retry   = 1'b0;
    give_up = (tmr == TMO_LAST) || (inv_lock && flip_done);
    if (!bus.link_req) begin
      ns = ST_IDLE;
    end else begin
      unique case (st)
        ST_IDLE: ns = ST_TRAIN;
        ST_TRAIN: begin
          if (lock)                        ns = ST_LINKED;
          else if (inv_lock && !flip_done) flip = 1'b1;
          else if (give_up) begin
            if (retry_cnt == RTY_LAST) ns = ST_FAIL;
            else                       retry = 1'b1;
          end
        end
        ST_LINKED: if (loss_cnt == LOSS_LAST) ns = ST_TRAIN;
        default: ;
      endcase
    end

    cnt_en      = (st == ST_TRAIN) && (ns == ST_TRAIN) && !flip && !retry;
    linked_run  = (st == ST_LINKED) && (ns == ST_LINKED);
    mac_ready_c = (st == ST_LINKED) && (skip_cnt != SKIP_LAST);

    nxt_data = '0;
    nxt_en   = 1'b0;
    nxt_ph   = 1'b0;
    unique case (ns)
      ST_TRAIN: begin
        nxt_en   = 1'b1;
        nxt_data = (st == ST_TRAIN && train_ph) ? TRAIN_WORD : K285_RDN;
        nxt_ph   = (st == ST_TRAIN) ? ~train_ph : 1'b1;
      end
      ST_LINKED: begin
        nxt_en   = 1'b1;
        nxt_data = (mac_ready_c && bus.mac_valid) ? bus.mac_data : K285_RDN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Bit_Rate_Clk_10 or negedge Rst_n) begin
    if (!Rst_n) begin
      tmr        <= '0;
      retry_cnt  <= '0;
      skip_cnt   <= '0;
      loss_cnt   <= '0;
      rx_pol     <= 1'b0;
      flip_done  <= 1'b0;
      train_ph   <= 1'b0;
      pma_data_q <= '0;
      pma_en_q   <= 1'b0;
    end else begin
      pma_data_q <= nxt_data;
      pma_en_q   <= nxt_en;
      train_ph   <= nxt_ph;
      if (st == ST_IDLE && ns == ST_TRAIN) begin
        retry_cnt <= '0;
        rx_pol    <= 1'b0;
        flip_done <= 1'b0;
      end else if (flip) begin
        rx_pol    <= ~rx_pol;
        flip_done <= 1'b1;
      end else if (retry) begin
        retry_cnt <= retry_cnt + 1'b1;
        rx_pol    <= 1'b0;
        flip_done <= 1'b0;
      end
      tmr      <= cnt_en ? tmr + 1'b1 : '0;
      skip_cnt <= !linked_run ? '0 : (skip_cnt == SKIP_LAST) ? '0 : skip_cnt + 1'b1;
      loss_cnt <= !linked_run ? '0 : comma_seen ? '0 : loss_cnt + 1'b1;
    end
  end

  assign bus.mac_ready   = mac_ready_c;
  assign bus.pma_data    = pma_data_q;
  assign bus.pma_data_en = pma_en_q;
  assign bus.RxPolarity  = rx_pol;
  assign bus.link_up     = (st == ST_LINKED);
  assign bus.link_fail   = (st == ST_FAIL);
  assign bus.state       = st;

endmodule

// File: tb/tb_pma_link_ctrl.sv
// Randomized bench for pma_link_ctrl with a cycle-level behavioural model
// plus directed scenarios pinned by hand-derived cycle counts.
module tb_pma_link_ctrl;
  import pma_link_ctrl_pkg::*;

  localparam int         LOCK = 16;
  localparam int         TMO  = 64;
  localparam int         MAXR = 2;
  localparam int         SKIP = 8;
  localparam int         LOSS = 32;
  localparam logic [9:0] TW   = 10'b0110110101;
  localparam logic [9:0] TWN  = ~TW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pma_link_ctrl_if #(.DATA_WIDTH(10)) bus();

  pma_link_ctrl #(
    .DATA_WIDTH(10), .TRAIN_WORD(TW), .LOCK_CNT(LOCK), .TIMEOUT_CYC(TMO),
    .MAX_RETRY(MAXR), .SKIP_INT(SKIP), .LOSS_CYC(LOSS)
  ) dut (
    .Bit_Rate_Clk_10 (clk),
    .Rst_n           (rst_n),
    .bus             (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_st = 0, m_retry = 0, m_pol = 0, m_flip = 0;
  int         m_good = 0, m_inv = 0, m_tmr = 0, m_skip = 0, m_loss = 0, m_idx = 0;
  int         m_en = 0;
  logic [9:0] m_data = '0;
  logic [9:0] m_rxq = '0;

  task automatic model_reset();
    m_st = 0; m_retry = 0; m_pol = 0; m_flip = 0; m_good = 0; m_inv = 0;
    m_tmr = 0; m_skip = 0; m_loss = 0; m_idx = 0; m_en = 0; m_data = '0; m_rxq = '0;
  endtask

  task automatic model_step();
    int  nst, cls;
    bit  ready, restart;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_rxq == K285_RDN || m_rxq == K285_RDP || m_rxq == TW) cls = 1;
    else if (m_rxq == TWN) cls = 2;
    else cls = 0;
    ready   = (m_st == 2) && (m_skip != SKIP - 1);
    nst     = m_st;
    restart = 0;
    if (!bus.link_req) nst = 0;
    else if (m_st == 0) begin
      nst = 1; m_retry = 0; m_pol = 0; m_flip = 0;
    end else if (m_st == 1) begin
      if (m_good == LOCK) nst = 2;
      else if (m_inv == LOCK && m_flip == 0) begin
        m_pol = 1 - m_pol; m_flip = 1; restart = 1;
      end else if (m_tmr == TMO - 1 || m_inv == LOCK) begin
        if (m_retry + 1 == MAXR) nst = 3;
        else begin m_retry++; m_pol = 0; m_flip = 0; restart = 1; end
      end
    end else if (m_st == 2) begin
      if (m_loss == LOSS - 1) nst = 1;
    end

    if (m_st == 1 && nst == 1 && !restart) begin
      m_tmr++;
      if (cls == 1) begin m_good = (m_good + 1 > LOCK) ? LOCK : m_good + 1; m_inv = 0; end
      else if (cls == 2) begin m_inv = (m_inv + 1 > LOCK) ? LOCK : m_inv + 1; m_good = 0; end
      else begin m_good = 0; m_inv = 0; end
    end else begin
      m_tmr = 0; m_good = 0; m_inv = 0;
    end

    if (m_st == 2 && nst == 2) begin
      m_skip = (m_skip + 1) % SKIP;
      m_loss = (bus.rx_word == K285_RDN || bus.rx_word == K285_RDP) ? 0 : m_loss + 1;
    end else begin
      m_skip = 0; m_loss = 0;
    end

    if (nst == 1) begin
      m_idx  = (m_st == 1) ? m_idx + 1 : 0;
      m_en   = 1;
      m_data = (m_idx % 2 == 1) ? TW : K285_RDN;
    end else if (nst == 2) begin
      m_en   = 1;
      m_data = (ready && bus.mac_valid) ? bus.mac_data : K285_RDN;
    end else begin
      m_en = 0; m_data = '0;
    end
    m_rxq = bus.rx_word;
    m_st  = nst;
  endtask

  always @(negedge clk) begin
    chk("state", int'(bus.state), m_st);
    chk("pma_data", int'(bus.pma_data), int'(m_data));
    chk("pma_data_en", int'(bus.pma_data_en), m_en);
    chk("RxPolarity", int'(bus.RxPolarity), m_pol);
    chk("link_up", int'(bus.link_up), int'(m_st == 2));
    chk("link_fail", int'(bus.link_fail), int'(m_st == 3));
    chk("mac_ready", int'(bus.mac_ready), int'(m_st == 2 && m_skip != SKIP - 1));
  end

  // ---------------- stimulus ----------------
  int         mode = 2;  // 0 loopback(3), 1 ~TW, 2 zero, 3 random class, 4 TW, 5 K28.5
  bit         mac_on = 0;
  logic [9:0] dl [3];

  task automatic tick();
    bit acc;
    acc = bus.mac_valid && bus.mac_ready;
    @(posedge clk);
    model_step();
    #1;
    dl[2] = dl[1]; dl[1] = dl[0]; dl[0] = bus.pma_data;
    case (mode)
      0: bus.rx_word = dl[2];
      1: bus.rx_word = TWN;
      2: bus.rx_word = '0;
      3: case ($urandom_range(4))
           0: bus.rx_word = K285_RDN;
           1: bus.rx_word = K285_RDP;
           2: bus.rx_word = TW;
           3: bus.rx_word = TWN;
           default: bus.rx_word = 10'($urandom);
         endcase
      4: bus.rx_word = TW;
      default: bus.rx_word = K285_RDN;
    endcase
    if (acc || !bus.mac_valid) begin
      bus.mac_valid = mac_on && ($urandom_range(3) != 0);
      bus.mac_data  = 10'($urandom);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n, cnt;
    bit         found;
    logic [9:0] held;
    for (int i = 0; i < 3; i++) dl[i] = '0;
    bus.link_req = 1'b0; bus.mac_valid = 1'b0; bus.mac_data = '0; bus.rx_word = '0;
    repeat (3) tick();
    chk("reset_state", int'(bus.state), 0);
    chk("reset_pma_en", int'(bus.pma_data_en), 0);
    #2 rst_n = 1'b1;

    // loopback lock: first echoed word sampled 3 edges after entry, 16 words, +2 pipeline
    mode = 0; mac_on = 1; bus.link_req = 1'b1; n = 0;
    for (int i = 0; i < 40; i++) begin tick(); n++; if (bus.link_up) break; end
    chk("lock_cycles", n, 21);
    chk("lock_polarity", int'(bus.RxPolarity), 0);

    // skip insertion: one stall every SKIP cycles
    cnt = 0;
    for (int i = 0; i < 32; i++) begin tick(); if (!bus.mac_ready) cnt++; end
    chk("skip_count", cnt, 4);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bus.mac_ready) begin found = 1; break; end
      tick();
    end
    chk("skip_seen", int'(found), 1);
    if (!bus.mac_valid) begin bus.mac_valid = 1'b1; bus.mac_data = 10'($urandom); end
    held = bus.mac_data;
    tick();
    chk("skip_word", int'(bus.pma_data), int'(K285_RDN));
    tick();
    chk("held_word", int'(bus.pma_data), int'(held));

    // comma loss: one K28.5, then zeros; drop on the 32nd zero
    bus.rx_word = K285_RDN; mode = 2;
    tick();
    n = 0;
    for (int i = 0; i < 40; i++) begin tick(); n++; if (bus.state != 2'd2) break; end
    chk("loss_cycles", n, 32);
    chk("loss_state", int'(bus.state), 1);
    chk("loss_link_up", int'(bus.link_up), 0);

    // timeout: two windows of 64 cycles, then FAIL
    bus.link_req = 1'b0; tick();
    chk("drop_to_idle", int'(bus.state), 0);
    bus.link_req = 1'b1; n = 0;
    for (int i = 0; i < 200; i++) begin tick(); n++; if (bus.state == 2'd3) break; end
    chk("fail_cycles", n, 129);
    chk("fail_flag", int'(bus.link_fail), 1);
    chk("fail_pma_en", int'(bus.pma_data_en), 0);
    tick();
    chk("fail_sticky", int'(bus.state), 3);
    bus.link_req = 1'b0; tick();
    chk("fail_release", int'(bus.state), 0);
    chk("fail_flag_clr", int'(bus.link_fail), 0);

    // inverted line: 16 inverted words sampled after entry, flip 2 edges later
    bus.rx_word = TWN; mode = 1; bus.link_req = 1'b1; n = 0;
    for (int i = 0; i < 40; i++) begin tick(); n++; if (bus.RxPolarity) break; end
    chk("flip_cycles", n, 18);
    mode = 0; found = 0;
    for (int i = 0; i < 60; i++) begin tick(); if (bus.link_up) begin found = 1; break; end end
    chk("relock_after_flip", int'(found), 1);
    chk("relock_polarity", int'(bus.RxPolarity), 1);

    // asynchronous reset mid-TRAIN, held with link_req=1
    bus.link_req = 1'b0; tick();
    bus.link_req = 1'b1; mode = 2;
    repeat (3) tick();
    chk("pre_rst_train", int'(bus.state), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_state", int'(bus.state), 0);
    chk("arst_pma_data", int'(bus.pma_data), 0);
    chk("arst_pma_en", int'(bus.pma_data_en), 0);
    chk("arst_link_up", int'(bus.link_up), 0);
    chk("arst_mac_ready", int'(bus.mac_ready), 0);
    for (int i = 0; i < 3; i++) begin tick(); chk("arst_hold", int'(bus.state), 0); end
    #2 rst_n = 1'b1;

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) mode = $urandom_range(5);
      bus.link_req = ($urandom_range(299) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
